// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM encoding, status counter width
// and a saturating increment helper.
package pll_seq_pkg;

    localparam int unsigned COUNT_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t PLL_RST   = 2'd0;
    localparam state_t WAIT_LOCK = 2'd1;
    localparam state_t STABLE    = 2'd2;
    localparam state_t RUN       = 2'd3;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        logic [COUNT_W-1:0] result;
        if (value == {COUNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Handshake bundle between the PLL / system side (master) and the reset sequencer (slave).
interface pll_reset_sequencer_if
    import pll_seq_pkg::*;
();

    logic               locked;
    logic               force_relock;
    logic               pll_rst;
    logic               rst_out;
    logic               ready;
    logic [COUNT_W-1:0] loss_count;
    logic [COUNT_W-1:0] retry_count;

    modport master (
        output locked,
        output force_relock,
        input  pll_rst,
        input  rst_out,
        input  ready,
        input  loss_count,
        input  retry_count
    );

    modport slave (
        input  locked,
        input  force_relock,
        output pll_rst,
        output rst_out,
        output ready,
        output loss_count,
        output retry_count
    );

endinterface

// File: rtl/sync_bit.sv
// N-flop synchronizer for a single asynchronous input; clears to 0 on async reset.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_bit: STAGES must be >= 2");
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset from the free-running board clock and releases the system reset
// only after the synchronized lock indication has been stable long enough.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLLRST_CYCLES  = 16,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clock,
    input  logic                 reset_n,
    pll_reset_sequencer_if.slave bus
);

    localparam int unsigned MAX_A     = (PLLRST_CYCLES > STABLE_CYCLES) ? PLLRST_CYCLES
                                                                          : STABLE_CYCLES;
    localparam int unsigned MAX_CYCLE = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(MAX_CYCLE) + 1;

    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLLRST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pll_reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (PLLRST_CYCLES < 1) begin : g_bad_pllrst
        $error("pll_reset_sequencer: PLLRST_CYCLES must be >= 1");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("pll_reset_sequencer: STABLE_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("pll_reset_sequencer: TIMEOUT_CYCLES must be >= 2");
    end

    logic locked_s;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync_locked (
        .clk_i (clock),
        .rst_ni(reset_n),
        .d_i   (bus.locked),
        .q_o   (locked_s)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COUNT_W-1:0] loss_q, loss_d;
    logic [COUNT_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, rst_out_q, ready_q;

    always_comb begin
        state_d = state_q;
        loss_d  = loss_q;
        retry_d = retry_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == PLLRST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (bus.force_relock) begin
                    state_d = PLL_RST;
                end else if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = PLL_RST;
                    retry_d = sat_inc(retry_q);
                end
            end
            STABLE: begin
                // A lock drop on the terminal count still sends us back to WAIT_LOCK.
                if (bus.force_relock) begin
                    state_d = PLL_RST;
                end else if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    loss_d  = sat_inc(loss_q);
                    state_d = bus.force_relock ? PLL_RST : WAIT_LOCK;
                end else if (bus.force_relock) begin
                    state_d = PLL_RST;
                end
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        // Shared timer: cleared on any transition, idle in RUN, never allowed to wrap.
        if (state_d != state_q || state_q == RUN) begin
            cnt_d = '0;
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            loss_q    <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == PLL_RST);
            rst_out_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.rst_out     = rst_out_q;
    assign bus.ready       = ready_q;
    assign bus.loss_count  = loss_q;
    assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a vector table walked edge by edge, plus
// hand-written sequences for timeout, drop-during-stable, saturation and async reset.
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES   (2),
        .PLLRST_CYCLES (4),
        .STABLE_CYCLES (8),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #20 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    typedef struct {
        logic locked;
        logic force_relock;
        int   n;
        logic pll_rst;
        logic rst_out;
        logic ready;
        int   loss;
        int   retry;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, ".pll_rst"}, int'(bus.pll_rst), int'(v.pll_rst));
        check({tag, ".rst_out"}, int'(bus.rst_out), int'(v.rst_out));
        check({tag, ".ready"},   int'(bus.ready),   int'(v.ready));
        check({tag, ".loss"},    int'(bus.loss_count),  v.loss);
        check({tag, ".retry"},   int'(bus.retry_count), v.retry);
    endtask

    initial begin
        int k;
        int stuck;

        //            lock force  n  prst rout rdy loss retry
        vecs[0]  = '{1'b0, 1'b0,  0, 1'b1, 1'b1, 1'b0, 0, 0}; // reset state
        vecs[1]  = '{1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0, 0}; // WAIT_LOCK
        vecs[3]  = '{1'b0, 1'b0, 31, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[4]  = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 0, 1}; // timeout
        vecs[5]  = '{1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0, 1};
        vecs[6]  = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0, 1};
        vecs[7]  = '{1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 0, 1}; // lock rise at t
        vecs[8]  = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1, 0, 1}; // RUN at t+11
        vecs[9]  = '{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b1, 0, 1}; // drop at t
        vecs[10] = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1, 1}; // seen at t+3
        vecs[11] = '{1'b1, 1'b0, 11, 1'b0, 1'b0, 1'b1, 1, 1};
        vecs[12] = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1, 1}; // force in RUN
        vecs[13] = '{1'b1, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1, 1};
        vecs[14] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1, 1};
        vecs[15] = '{1'b1, 1'b0,  8, 1'b0, 1'b1, 1'b0, 1, 1};
        vecs[16] = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1, 1, 1};
        vecs[17] = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1, 1};
        vecs[18] = '{1'b1, 1'b1,  3, 1'b1, 1'b1, 1'b0, 1, 1}; // ignored in PLL_RST
        vecs[19] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1, 1};
        vecs[20] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1, 1}; // STABLE
        vecs[21] = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1, 1}; // force in STABLE
        vecs[22] = '{1'b1, 1'b0,  4, 1'b0, 1'b1, 1'b0, 1, 1};

        bus.locked       = 1'b0;
        bus.force_relock = 1'b0;
        tick(2);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus.locked       = vecs[i].locked;
            bus.force_relock = vecs[i].force_relock;
            tick(vecs[i].n);
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end
        bus.force_relock = 1'b0;

        // Fresh start, let one timeout happen, then drop lock while in STABLE.
        bus.locked = 1'b0;
        #5 reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;

        k = 0;
        while (bus.pll_rst && k < 20) begin tick(1); k++; end
        check("pllrst_high_len", k, 4);
        k = 0;
        stuck = 0;
        while (!bus.pll_rst && k < 50) begin
            if (!bus.rst_out) stuck++;
            tick(1);
            k++;
        end
        check("wait_lock_len", k, 32);
        check("rst_out_held_in_wait", stuck, 0);
        check("retry_after_timeout", int'(bus.retry_count), 1);
        k = 0;
        while (bus.pll_rst && k < 20) begin tick(1); k++; end
        check("pllrst_restart_len", k, 4);

        bus.locked = 1'b1;
        tick(8);
        check("stable_cnt5_rst_out", int'(bus.rst_out), 1);
        bus.locked = 1'b0;
        tick(3);
        check("drop_wins_ready", int'(bus.ready), 0);
        check("drop_wins_rst_out", int'(bus.rst_out), 1);
        bus.locked = 1'b1;
        k = 0;
        while (bus.rst_out && k < 40) begin tick(1); k++; end
        check("rerise_latency", k, 11);
        check("rerise_ready", int'(bus.ready), 1);
        check("rerise_loss", int'(bus.loss_count), 0);

        // Loss in RUN, then drive the loss counter into saturation.
        bus.locked = 1'b0;
        k = 0;
        while (bus.ready && k < 10) begin tick(1); k++; end
        check("loss_latency", k, 3);
        check("loss_rst_out", int'(bus.rst_out), 1);
        check("loss_count_1", int'(bus.loss_count), 1);

        stuck = 0;
        for (int c = 0; c < 300; c++) begin
            bus.locked = 1'b1;
            k = 0;
            while (!bus.ready && k < 30) begin tick(1); k++; end
            if (k >= 30) stuck++;
            bus.locked = 1'b0;
            k = 0;
            while (bus.ready && k < 10) begin tick(1); k++; end
            if (k >= 10) stuck++;
        end
        check("sat_loop_timeouts", stuck, 0);
        check("loss_saturated", int'(bus.loss_count), 255);
        check("retry_unchanged", int'(bus.retry_count), 1);

        bus.locked = 1'b1;
        k = 0;
        while (!bus.ready && k < 30) begin tick(1); k++; end
        check("relock_after_sat", k, 11);
        bus.locked = 1'b0;
        tick(3);
        check("loss_holds_255", int'(bus.loss_count), 255);
        bus.locked = 1'b1;
        tick(11);
        check("run_before_async_reset", int'(bus.ready), 1);

        // Asynchronous reset between edges during RUN.
        @(posedge clock);
        #5 reset_n = 1'b0;
        #2;
        check("async_pll_rst", int'(bus.pll_rst), 1);
        check("async_rst_out", int'(bus.rst_out), 1);
        check("async_ready",   int'(bus.ready), 0);
        check("async_loss",    int'(bus.loss_count), 0);
        check("async_retry",   int'(bus.retry_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
